// File: rtl/fixed_adder_tree_arbiter.sv
// fixed_adder_tree_arbiter
// Shares one externally instantiated pipelined adder tree among NUM_REQ
// requesters. A round-robin grant picks the vector sent to the tree. A tag
// FIFO records the grant order, so each returning sum is steered back to the
// requester that issued it, strictly in issue order.
//
// Ports
//   clk            clock; all state changes on the rising edge
//   rst            asynchronous, active-low reset
//   req_data       packed requester vectors; requester r element e is at
//                  [(r*IN_SIZE+e)*IN_WIDTH +: IN_WIDTH]
//   req_valid      per-requester valid
//   req_ready      per-requester ready (at most one bit high)
//   resp_data      sum returned by the tree, shared by all requesters
//   resp_valid     one-hot response valid
//   resp_ready     per-requester response ready
//   tree_data_in   vector presented to the tree
//   tree_in_valid  tree input valid
//   tree_in_ready  tree input ready
//   tree_data_out  sum from the tree
//   tree_out_valid tree output valid
//   tree_out_ready tree output ready
//   inflight       tag FIFO occupancy (issued but not yet returned)
module fixed_adder_tree_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int IN_SIZE      = 4,
    parameter int IN_WIDTH     = 16,
    parameter int OUT_WIDTH    = $clog2(IN_SIZE) + IN_WIDTH,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NUM_REQ*IN_SIZE*IN_WIDTH-1:0]    req_data,
    input  logic [NUM_REQ-1:0]                     req_valid,
    output logic [NUM_REQ-1:0]                     req_ready,
    output logic [OUT_WIDTH-1:0]                   resp_data,
    output logic [NUM_REQ-1:0]                     resp_valid,
    input  logic [NUM_REQ-1:0]                     resp_ready,
    output logic [IN_SIZE*IN_WIDTH-1:0]            tree_data_in,
    output logic                                   tree_in_valid,
    input  logic                                   tree_in_ready,
    input  logic [OUT_WIDTH-1:0]                   tree_data_out,
    input  logic                                   tree_out_valid,
    output logic                                   tree_out_ready,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0]      inflight
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PTR_W = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
    localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
    localparam int VEC_W = IN_SIZE * IN_WIDTH;

    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] r_tags [MAX_INFLIGHT];
    logic [PTR_W-1:0] r_wr;
    logic [PTR_W-1:0] r_rd;
    logic [CNT_W-1:0] r_count;

    logic [NUM_REQ-1:0] w_grant;
    logic [IDX_W-1:0]   w_win;
    logic [IDX_W-1:0]   w_k;
    logic [IDX_W-1:0]   w_head;
    logic               w_any;
    logic               w_empty;
    logic               w_full;
    logic               w_push;
    logic               w_pop;

    // Circular pointer advance; depth need not be a power of two.
    function automatic logic [PTR_W-1:0] f_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_INFLIGHT - 1)) ? '0 : p + 1'b1;
    endfunction

    // Round-robin: scan from ptr+1 upward with wrap, first valid wins.
    always_comb begin
        w_grant = '0;
        w_win   = '0;
        w_any   = 1'b0;
        w_k     = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            w_k = IDX_W'((32'(r_ptr) + i) % NUM_REQ);
            if (!w_any && req_valid[w_k]) begin
                w_any          = 1'b1;
                w_win          = w_k;
                w_grant[w_k]   = 1'b1;
            end
        end
    end

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(MAX_INFLIGHT));

    // Issue side depends only on req_valid and registered occupancy, so the
    // full check never sees a same-cycle pop.
    assign tree_in_valid = rst & w_any & ~w_full;
    assign tree_data_in  = req_data[w_win*VEC_W +: VEC_W];
    assign req_ready     = w_grant & {NUM_REQ{rst & tree_in_ready & ~w_full}};
    assign w_push        = tree_in_valid & tree_in_ready;

    // Return side: the FIFO head selects the requester that owns the sum.
    assign w_head         = r_tags[r_rd];
    assign tree_out_ready = rst & ~w_empty & resp_ready[w_head];
    assign resp_valid     = (rst & tree_out_valid & ~w_empty) ?
                            (NUM_REQ'(1) << w_head) : '0;
    assign resp_data      = tree_data_out;
    assign w_pop          = tree_out_valid & tree_out_ready;

    assign inflight = r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr   <= IDX_W'(NUM_REQ - 1);
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_ptr <= w_win;
                r_wr  <= f_next(r_wr);
            end
            if (w_pop) begin
                r_rd <= f_next(r_rd);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Tag storage needs no reset: entries are only read behind valid pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_tags[r_wr] <= w_win;
        end
    end

endmodule

// File: tb/tb_fixed_adder_tree_arbiter.sv
module tb_fixed_adder_tree_arbiter;

    localparam int NUM_REQ = 4;
    localparam int IN_SIZE = 4;
    localparam int IN_WIDTH = 16;
    localparam int OUT_WIDTH = 18;
    localparam int MAX_INFLIGHT = 4;

    logic                                clk = 1'b0;
    logic                                rst = 1'b0;
    logic [NUM_REQ*IN_SIZE*IN_WIDTH-1:0] req_data = '0;
    logic [NUM_REQ-1:0]                  req_valid = '0;
    logic [NUM_REQ-1:0]                  req_ready;
    logic [OUT_WIDTH-1:0]                resp_data;
    logic [NUM_REQ-1:0]                  resp_valid;
    logic [NUM_REQ-1:0]                  resp_ready = '0;
    logic [IN_SIZE*IN_WIDTH-1:0]         tree_data_in;
    logic                                tree_in_valid;
    logic                                tree_in_ready = 1'b1;
    logic [OUT_WIDTH-1:0]                tree_data_out;
    logic                                tree_out_valid;
    logic                                tree_out_ready;
    logic [2:0]                          inflight;

    fixed_adder_tree_arbiter #(
        .NUM_REQ(NUM_REQ),
        .IN_SIZE(IN_SIZE),
        .IN_WIDTH(IN_WIDTH),
        .OUT_WIDTH(OUT_WIDTH),
        .MAX_INFLIGHT(MAX_INFLIGHT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_data(req_data),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .resp_data(resp_data),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .tree_data_in(tree_data_in),
        .tree_in_valid(tree_in_valid),
        .tree_in_ready(tree_in_ready),
        .tree_data_out(tree_data_out),
        .tree_out_valid(tree_out_valid),
        .tree_out_ready(tree_out_ready),
        .inflight(inflight)
    );

    always #5 clk = ~clk;

    // Behavioural adder tree: elastic queue of signed sums, reset by rst.
    logic [OUT_WIDTH-1:0] m_mem [8];
    int                   m_wr;
    int                   m_rd;
    logic                 tb_bogus = 1'b0;

    assign tree_out_valid = tb_bogus | (m_wr != m_rd);
    assign tree_data_out  = (m_wr != m_rd) ? m_mem[m_rd % 8] : '0;

    // Observed traffic logs
    int                   iss_log [64];
    int                   rsp_idx [64];
    logic [OUT_WIDTH-1:0] rsp_dat [64];
    int                   n_iss;
    int                   n_rsp;

    function automatic int onehot_idx(input logic [NUM_REQ-1:0] v);
        int r;
        r = 7;
        if ($onehot(v)) begin
            for (int i = 0; i < NUM_REQ; i++) if (v[i]) r = i;
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_wr <= 0;
            m_rd <= 0;
        end else begin
            if (tree_in_valid && tree_in_ready) begin
                logic [OUT_WIDTH-1:0] s;
                logic [IN_WIDTH-1:0]  d;
                s = '0;
                for (int e = 0; e < IN_SIZE; e++) begin
                    d = tree_data_in[e*IN_WIDTH +: IN_WIDTH];
                    s = s + {{(OUT_WIDTH-IN_WIDTH){d[IN_WIDTH-1]}}, d};
                end
                m_mem[m_wr % 8] <= s;
                m_wr <= m_wr + 1;
                if (n_iss < 64) iss_log[n_iss] <= onehot_idx(req_ready);
                n_iss <= n_iss + 1;
            end
            if (tree_out_valid && tree_out_ready && !tb_bogus) begin
                m_rd <= m_rd + 1;
                if (n_rsp < 64) begin
                    rsp_idx[n_rsp] <= onehot_idx(resp_valid & resp_ready);
                    rsp_dat[n_rsp] <= resp_data;
                end
                n_rsp <= n_rsp + 1;
            end
        end
    end

    initial begin
        n_iss = 0;
        n_rsp = 0;
    end

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_vec(input int r, input logic [15:0] e0, input logic [15:0] e1,
                           input logic [15:0] e2, input logic [15:0] e3);
        req_data[(r*IN_SIZE+0)*IN_WIDTH +: IN_WIDTH] = e0;
        req_data[(r*IN_SIZE+1)*IN_WIDTH +: IN_WIDTH] = e1;
        req_data[(r*IN_SIZE+2)*IN_WIDTH +: IN_WIDTH] = e2;
        req_data[(r*IN_SIZE+3)*IN_WIDTH +: IN_WIDTH] = e3;
    endtask

    int b_i;
    int b_r;

    initial begin
        // Reset state with live-looking inputs
        req_valid  = 4'hF;
        resp_ready = 4'hF;
        #1;
        check("rst_req_ready", 64'(req_ready), 64'h0);
        check("rst_tree_in_valid", 64'(tree_in_valid), 64'h0);
        check("rst_tree_out_ready", 64'(tree_out_ready), 64'h0);
        check("rst_resp_valid", 64'(resp_valid), 64'h0);
        check("rst_inflight", 64'(inflight), 64'h0);
        req_valid  = '0;
        resp_ready = '0;
        tick();
        rst = 1'b1;
        tick();

        // Single requester 1, vector {1,2,3,4}
        set_vec(0, 16'd1, 16'd1, 16'd1, 16'd1);
        set_vec(1, 16'd1, 16'd2, 16'd3, 16'd4);
        set_vec(2, 16'd10, 16'd20, 16'd30, 16'd40);
        set_vec(3, 16'd100, 16'd200, 16'd300, 16'd400);
        req_valid  = 4'b0010;
        resp_ready = 4'hF;
        #1;
        check("single_req_ready", 64'(req_ready), 64'h2);
        check("single_tree_in_valid", 64'(tree_in_valid), 64'h1);
        check("single_tree_data_in", 64'(tree_data_in), 64'h0004_0003_0002_0001);
        tick();
        req_valid = '0;
        #1;
        check("single_inflight1", 64'(inflight), 64'h1);
        check("single_resp_valid", 64'(resp_valid), 64'h2);
        check("single_resp_data", 64'(resp_data), 64'd10);
        check("single_tree_out_ready", 64'(tree_out_ready), 64'h1);
        tick();
        check("single_inflight0", 64'(inflight), 64'h0);
        check("single_resp_valid_clr", 64'(resp_valid), 64'h0);

        // Fresh reset so requester 0 again has first priority
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();

        // Full contention, all ready
        b_i = n_iss;
        b_r = n_rsp;
        req_valid  = 4'hF;
        resp_ready = 4'hF;
        repeat (6) tick();
        req_valid = '0;
        repeat (3) tick();
        check("cont_n_iss", 64'(n_iss - b_i), 64'd6);
        check("cont_n_rsp", 64'(n_rsp - b_r), 64'd6);
        check("cont_iss0", 64'(iss_log[b_i+0]), 64'd0);
        check("cont_iss1", 64'(iss_log[b_i+1]), 64'd1);
        check("cont_iss2", 64'(iss_log[b_i+2]), 64'd2);
        check("cont_iss3", 64'(iss_log[b_i+3]), 64'd3);
        check("cont_iss4", 64'(iss_log[b_i+4]), 64'd0);
        check("cont_iss5", 64'(iss_log[b_i+5]), 64'd1);
        check("cont_rsp0_idx", 64'(rsp_idx[b_r+0]), 64'd0);
        check("cont_rsp0_dat", 64'(rsp_dat[b_r+0]), 64'd4);
        check("cont_rsp1_idx", 64'(rsp_idx[b_r+1]), 64'd1);
        check("cont_rsp1_dat", 64'(rsp_dat[b_r+1]), 64'd10);
        check("cont_rsp2_idx", 64'(rsp_idx[b_r+2]), 64'd2);
        check("cont_rsp2_dat", 64'(rsp_dat[b_r+2]), 64'd100);
        check("cont_rsp3_idx", 64'(rsp_idx[b_r+3]), 64'd3);
        check("cont_rsp3_dat", 64'(rsp_dat[b_r+3]), 64'd1000);
        check("cont_rsp5_idx", 64'(rsp_idx[b_r+5]), 64'd1);
        check("cont_rsp5_dat", 64'(rsp_dat[b_r+5]), 64'd10);
        check("cont_inflight0", 64'(inflight), 64'h0);

        // In-flight cap: returns held off, ptr=1 so order 2,3,0,1
        b_i = n_iss;
        resp_ready = '0;
        req_valid  = 4'hF;
        repeat (4) tick();
        check("cap_inflight4", 64'(inflight), 64'd4);
        check("cap_tree_in_valid", 64'(tree_in_valid), 64'h0);
        check("cap_req_ready", 64'(req_ready), 64'h0);
        check("cap_head_resp_valid", 64'(resp_valid), 64'h4);
        check("cap_head_resp_data", 64'(resp_data), 64'd100);
        tick();
        check("cap_no_extra_issue", 64'(n_iss - b_i), 64'd4);
        resp_ready = 4'hF;
        #1;
        check("cap_pop_ready", 64'(tree_out_ready), 64'h1);
        check("cap_full_blocks_on_pop", 64'(tree_in_valid), 64'h0);
        tick();
        resp_ready = '0;
        #1;
        check("cap_inflight3", 64'(inflight), 64'd3);
        check("cap_reissue_ready", 64'(req_ready), 64'h4);
        tick();
        check("cap_inflight4b", 64'(inflight), 64'd4);
        check("cap_tree_in_valid_b", 64'(tree_in_valid), 64'h0);
        check("cap_one_more_issue", 64'(n_iss - b_i), 64'd5);
        req_valid  = '0;
        resp_ready = 4'hF;
        repeat (5) tick();
        check("cap_drain_inflight", 64'(inflight), 64'h0);

        // Head-of-line: ptr=2, issue req2 then req0, stall req2's response
        b_r = n_rsp;
        resp_ready = 4'b1011;
        req_valid  = 4'b0100;
        tick();
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        check("hol_inflight2", 64'(inflight), 64'd2);
        for (int c = 0; c < 5; c++) begin
            check("hol_stalled_resp_valid", 64'(resp_valid), 64'h4);
            tick();
        end
        check("hol_no_rsp_while_stalled", 64'(n_rsp - b_r), 64'd0);
        resp_ready = 4'hF;
        #1;
        check("hol_head_data", 64'(resp_data), 64'd100);
        tick();
        check("hol_next_resp_valid", 64'(resp_valid), 64'h1);
        check("hol_next_resp_data", 64'(resp_data), 64'd4);
        tick();
        check("hol_inflight0", 64'(inflight), 64'h0);
        check("hol_order_idx1", 64'(rsp_idx[b_r+1]), 64'd0);

        // Sparse and wrap: drive ptr to 3, then only req 0 and req 3 valid
        set_vec(3, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        b_r = n_rsp;
        req_valid = 4'b1000;
        tick();
        req_valid = 4'b1001;
        #1;
        check("wrap_first_grant", 64'(req_ready), 64'h1);
        tick();
        #1;
        check("wrap_second_grant", 64'(req_ready), 64'h8);
        check("wrap_signed_vec", 64'(tree_data_in), 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        req_valid = '0;
        repeat (3) tick();
        check("wrap_rsp0_idx", 64'(rsp_idx[b_r+0]), 64'd3);
        check("wrap_rsp0_dat", 64'(rsp_dat[b_r+0]), 64'h3FFFC);
        check("wrap_rsp1_idx", 64'(rsp_idx[b_r+1]), 64'd0);
        check("wrap_rsp1_dat", 64'(rsp_dat[b_r+1]), 64'd4);
        check("wrap_rsp2_dat", 64'(rsp_dat[b_r+2]), 64'h3FFFC);
        check("wrap_inflight0", 64'(inflight), 64'h0);

        // Reset mid-operation with three in flight
        resp_ready = '0;
        req_valid  = 4'hF;
        repeat (3) tick();
        check("mid_inflight3", 64'(inflight), 64'd3);
        resp_ready = 4'hF;
        rst = 1'b0;
        #1;
        check("mid_rst_inflight", 64'(inflight), 64'h0);
        check("mid_rst_req_ready", 64'(req_ready), 64'h0);
        check("mid_rst_tree_in_valid", 64'(tree_in_valid), 64'h0);
        check("mid_rst_resp_valid", 64'(resp_valid), 64'h0);
        check("mid_rst_tree_out_ready", 64'(tree_out_ready), 64'h0);
        tick();
        rst = 1'b1;
        resp_ready = '0;
        #1;
        check("mid_after_grant", 64'(req_ready), 64'h1);
        b_i = n_iss;
        tick();
        check("mid_after_iss_idx", 64'(iss_log[b_i]), 64'd0);
        check("mid_after_inflight1", 64'(inflight), 64'd1);
        req_valid  = '0;
        resp_ready = 4'hF;
        repeat (2) tick();
        check("mid_after_drain", 64'(inflight), 64'h0);

        // Protocol error: tree output valid with empty tag FIFO
        tb_bogus = 1'b1;
        #1;
        check("err_tree_out_ready", 64'(tree_out_ready), 64'h0);
        check("err_resp_valid", 64'(resp_valid), 64'h0);
        tb_bogus = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
